// File: rtl/spi_slave_shifter.sv
// SPI slave shift engine: configurable width, CPOL/CPHA and bit order, with buffered TX and RX strobe.
// Build option: define SPI_SLAVE_UNDERRUN_EN to add the tx_underrun output.
module spi_slave_shifter #(
  parameter int          WIDTH     = 8,
  parameter int          CPOL      = 0,
  parameter int          CPHA      = 0,
  parameter int          LSB_FIRST = 0,
  parameter logic [31:0] IDLE_WORD = 32'h0000_007E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic             tx_underrun
`endif
);

  // state  | meaning
  // IDLE   | ss high, miso held low
  // LOAD   | one cycle: next TX word taken from holding buffer or IDLE_WORD
  // ACTIVE | word in progress, sample/shift on synchronised sclk edges

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] IDLE_W = IDLE_WORD[WIDTH-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACTIVE} state_t;

  state_t          state;
  logic            sclk_meta, sclk_sync, sclk_prev;
  logic            ss_meta, ss_sync, ss_prev;
  logic            mosi_meta, mosi_sync;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] tx_buf, tx_sr, rx_sr;
  logic            underrun;

  logic rise, fall, lead, trail, sample_edge, shift_edge, ss_fall, take_load;
  logic [WIDTH-1:0] rx_next, load_word;

  assign rise        = sclk_sync & ~sclk_prev;
  assign fall        = ~sclk_sync & sclk_prev;
  assign lead        = (CPOL == 0) ? rise : fall;
  assign trail       = (CPOL == 0) ? fall : rise;
  assign sample_edge = (CPHA == 0) ? lead : trail;
  assign shift_edge  = (CPHA == 0) ? trail : lead;
  assign ss_fall     = ss_prev & ~ss_sync;
  assign rx_next     = (LSB_FIRST != 0) ? {mosi_sync, rx_sr[WIDTH-1:1]}
                                        : {rx_sr[WIDTH-2:0], mosi_sync};
  assign load_word   = tx_ready ? IDLE_W : tx_buf;
  // A load arriving in the LOAD cycle is accepted because that cycle frees the buffer.
  assign take_load   = tx_load & (tx_ready | (state == ST_LOAD));

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sclk_meta <= (CPOL != 0);
      sclk_sync <= (CPOL != 0);
      sclk_prev <= (CPOL != 0);
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      cnt       <= '0;
      tx_buf    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      miso      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      ss_meta   <= ss;
      ss_sync   <= ss_meta;
      ss_prev   <= ss_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;

      if (take_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (state == ST_LOAD) begin
        tx_ready <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          cnt  <= '0;
          busy <= 1'b0;
          if (ss_fall) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          underrun <= tx_ready;
          cnt      <= '0;
          state    <= ST_ACTIVE;
          if (CPHA == 0) begin
            miso  <= first_bit(load_word);
            tx_sr <= shift_out(load_word);
          end else begin
            tx_sr <= load_word;
          end
        end
        ST_ACTIVE: begin
          if (ss_sync) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (cnt == CW'(WIDTH - 1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                cnt      <= '0;
                state    <= ST_LOAD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            // With CPHA=0 the trailing edge left over from the previous word carries no new bit.
            if (shift_edge && ((CPHA != 0) || (cnt != '0))) begin
              miso  <= first_bit(tx_sr);
              tx_sr <= shift_out(tx_sr);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  assign tx_underrun = underrun;
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: three instances (mode 0 / mode 3 / 16-bit LSB-first) driven by a bit-level SPI master.
module tb_spi_slave_shifter;

  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  sclk_r    = 3'b010;
  logic [2:0]  ss_r      = 3'b111;
  logic [2:0]  mosi_r    = 3'b000;
  logic [2:0]  tx_load_r = 3'b000;
  logic [7:0]  txd0 = '0, txd1 = '0;
  logic [15:0] txd2 = '0;
  wire  [2:0]  miso_w, tx_ready_w, rx_valid_w, busy_w;
  wire  [7:0]  rx0, rx1;
  wire  [15:0] rx2;
`ifdef SPI_SLAVE_UNDERRUN_EN
  wire  [2:0]  und_w;
`endif

  spi_slave_shifter u0 (
    .clk(clk), .rst(rst), .sclk(sclk_r[0]), .ss(ss_r[0]), .mosi(mosi_r[0]), .miso(miso_w[0]),
    .tx_data(txd0), .tx_load(tx_load_r[0]), .tx_ready(tx_ready_w[0]), .rx_data(rx0),
    .rx_valid(rx_valid_w[0]), .busy(busy_w[0])
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .tx_underrun(und_w[0])
`endif
  );

  spi_slave_shifter #(.CPOL(1), .CPHA(1)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk_r[1]), .ss(ss_r[1]), .mosi(mosi_r[1]), .miso(miso_w[1]),
    .tx_data(txd1), .tx_load(tx_load_r[1]), .tx_ready(tx_ready_w[1]), .rx_data(rx1),
    .rx_valid(rx_valid_w[1]), .busy(busy_w[1])
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .tx_underrun(und_w[1])
`endif
  );

  spi_slave_shifter #(.WIDTH(16), .LSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk_r[2]), .ss(ss_r[2]), .mosi(mosi_r[2]), .miso(miso_w[2]),
    .tx_data(txd2), .tx_load(tx_load_r[2]), .tx_ready(tx_ready_w[2]), .rx_data(rx2),
    .rx_valid(rx_valid_w[2]), .busy(busy_w[2])
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .tx_underrun(und_w[2])
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt[3] = '{0, 0, 0};
  int vcyc[3] = '{0, 0, 0};
  int edge_cyc[3] = '{0, 0, 0};
  int exp_vcnt[3] = '{0, 0, 0};
  bit mdl_full[3] = '{0, 0, 0};
  logic [31:0] mdl_buf[3];
  logic [31:0] mdl_nxt[3];
`ifdef SPI_SLAVE_UNDERRUN_EN
  int ucnt[3] = '{0, 0, 0};
  int exp_und[3] = '{0, 0, 0};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid_w[i]) begin
        vcnt[i] = vcnt[i] + 1;
        vcyc[i] = cyc;
      end
`ifdef SPI_SLAVE_UNDERRUN_EN
      if (und_w[i]) ucnt[i] = ucnt[i] + 1;
`endif
    end
  end

  function automatic int width_of(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] rx_of(input int i);
    case (i)
      0:       return {24'b0, rx0};
      1:       return {24'b0, rx1};
      default: return {16'b0, rx2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: each LOAD takes the buffered word if one is pending, else the idle word.
  task automatic consume(input int i, output logic [31:0] w);
    w = mdl_full[i] ? mdl_buf[i] : 32'h0000_007E;
`ifdef SPI_SLAVE_UNDERRUN_EN
    if (!mdl_full[i]) exp_und[i]++;
`endif
    mdl_full[i] = 1'b0;
  endtask

  task automatic load(input int i, input logic [31:0] word);
    @(negedge clk);
    case (i)
      0:       txd0 = word[7:0];
      1:       txd1 = word[7:0];
      default: txd2 = word[15:0];
    endcase
    tx_load_r[i] = 1'b1;
    if (!mdl_full[i]) begin
      mdl_full[i] = 1'b1;
      mdl_buf[i]  = word & mask_of(i);
    end
    @(negedge clk);
    tx_load_r[i] = 1'b0;
  endtask

  task automatic xfer(input int i, input logic [31:0] mw, input int nsamp, input bit keep_low,
                      input bit mid_load, input logic [31:0] ld_word,
                      output logic [31:0] got, output logic [31:0] exp_tx);
    int w;
    int pos;
    bit cpha;
    w    = width_of(i);
    cpha = (i == 1);
    got  = '0;
    if (ss_r[i]) begin
      consume(i, exp_tx);
      @(negedge clk);
      ss_r[i] = 1'b0;
      repeat (8) @(negedge clk);
      chk("tx_ready_after_load", {31'b0, tx_ready_w[i]}, {31'b0, ~mdl_full[i]});
`ifdef SPI_SLAVE_UNDERRUN_EN
      chk("underrun_count_start", ucnt[i], exp_und[i]);
`endif
    end else begin
      exp_tx = mdl_nxt[i];
    end
    for (int b = 0; b < nsamp; b++) begin
      pos = (i == 2) ? b : (w - 1 - b);
      if (!cpha) begin
        mosi_r[i] = mw[pos];
        repeat (HALF) @(negedge clk);
        sclk_r[i] = ~sclk_r[i];
        got[pos]  = miso_w[i];
        if (b == nsamp - 1) edge_cyc[i] = cyc;
        repeat (HALF) @(negedge clk);
        sclk_r[i] = ~sclk_r[i];
      end else begin
        sclk_r[i] = ~sclk_r[i];
        mosi_r[i] = mw[pos];
        repeat (HALF) @(negedge clk);
        got[pos]  = miso_w[i];
        sclk_r[i] = ~sclk_r[i];
        if (b == nsamp - 1) edge_cyc[i] = cyc;
        repeat (HALF) @(negedge clk);
      end
      if (b == 1) chk("busy_mid_word", {31'b0, busy_w[i]}, 32'd1);
      if (mid_load && b == 2) load(i, ld_word);
    end
    if (nsamp == w) begin
      exp_vcnt[i]++;
      consume(i, mdl_nxt[i]);
    end
    if (!keep_low) begin
      repeat (HALF) @(negedge clk);
      ss_r[i] = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  logic [31:0] got, exp_tx, mw, prev_rx;
  int          inst;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_miso", {31'b0, miso_w[0]}, 32'd0);
    chk("reset_rx_data", rx_of(0), 32'd0);
    chk("reset_rx_valid", {31'b0, rx_valid_w[0]}, 32'd0);
    chk("reset_tx_ready", {29'b0, tx_ready_w}, 32'd7);
    chk("reset_busy", {29'b0, busy_w}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0, buffered word 0x3C out, 0xA5 in
    load(0, 32'h3C);
    chk("tx_ready_after_capture", {31'b0, tx_ready_w[0]}, 32'd0);
    xfer(0, 32'hA5, 8, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("m0_miso_word", got, exp_tx);
    chk("m0_miso_is_3c", got, 32'h3C);
    chk("m0_rx_data", rx_of(0), 32'hA5);
    chk("m0_rx_valid_count", vcnt[0], exp_vcnt[0]);
    chk("m0_rx_valid_latency", vcyc[0] - edge_cyc[0], 32'd3);
    chk("m0_busy_after", {31'b0, busy_w[0]}, 32'd0);

    // Mode 3, nothing loaded: idle word out
    xfer(1, 32'hC3, 8, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("m3_miso_idle_word", got, 32'h7E);
    chk("m3_rx_data", rx_of(1), 32'hC3);
    chk("m3_rx_valid_count", vcnt[1], exp_vcnt[1]);

    // Back-to-back words with a load during word 1; the second load is ignored
    load(0, 32'h11);
    load(0, 32'h99);
    chk("tx_ready_full", {31'b0, tx_ready_w[0]}, 32'd0);
    xfer(0, 32'h6D, 8, 1'b1, 1'b1, 32'h22, got, exp_tx);
    chk("b2b_miso_w1", got, 32'h11);
    chk("b2b_rx_w1", rx_of(0), 32'h6D);
    xfer(0, 32'h93, 8, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("b2b_miso_w2", got, 32'h22);
    chk("b2b_rx_w2", rx_of(0), 32'h93);
    chk("b2b_rx_valid_count", vcnt[0], exp_vcnt[0]);

    // Abort after 3 sample edges
    prev_rx = rx_of(0);
    xfer(0, 32'hFF, 3, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("abort_no_rx_valid", vcnt[0], exp_vcnt[0]);
    chk("abort_rx_unchanged", rx_of(0), prev_rx);
    chk("abort_busy", {31'b0, busy_w[0]}, 32'd0);
    xfer(0, 32'h5A, 8, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("after_abort_rx", rx_of(0), 32'h5A);
    chk("after_abort_miso", got, exp_tx);

    // 16-bit LSB-first
    load(2, 32'hBEEF);
    xfer(2, 32'h1234, 16, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("lsb_miso_beef", got, 32'hBEEF);
    chk("lsb_rx_data", rx_of(2), 32'h1234);

    // Reset in the middle of a word
    xfer(0, 32'hE7, 5, 1'b1, 1'b0, 32'h0, got, exp_tx);
    @(negedge clk);
    rst = 1'b1;
    ss_r[0] = 1'b1;
    @(negedge clk);
    chk("midrst_miso", {31'b0, miso_w[0]}, 32'd0);
    chk("midrst_rx_data", rx_of(0), 32'd0);
    chk("midrst_rx_valid", vcnt[0], exp_vcnt[0]);
    chk("midrst_tx_ready", {31'b0, tx_ready_w[0]}, 32'd1);
    chk("midrst_busy", {31'b0, busy_w[0]}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mdl_full[k] = 1'b0;
    repeat (3) @(negedge clk);
    xfer(0, 32'h81, 8, 1'b0, 1'b0, 32'h0, got, exp_tx);
    chk("post_rst_rx", rx_of(0), 32'h81);
    chk("post_rst_miso", got, 32'h7E);

    // Randomised transfers against the model
    for (int k = 0; k < 9; k++) begin
      inst = $urandom_range(0, 2);
      mw   = $urandom & mask_of(inst);
      if ($urandom_range(0, 1) == 1) load(inst, $urandom & mask_of(inst));
      xfer(inst, mw, width_of(inst), 1'b0, 1'b0, 32'h0, got, exp_tx);
      chk("rand_miso", got, exp_tx);
      chk("rand_rx", rx_of(inst), mw);
      chk("rand_rx_valid_count", vcnt[inst], exp_vcnt[inst]);
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    for (int k = 0; k < 3; k++) chk("underrun_total", ucnt[k], exp_und[k]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
